// File: rtl/scramble_dn_loader_if.sv
// Download bus between the HPS ioctl port and the core ROM loader.
// The master drives ioctl_*; the slave returns the registered dn_* write port.
interface scramble_dn_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  dn_addr,
    input  dn_data,
    input  dn_wr,
    input  dn_region
  );

  modport slave (
    input  ioctl_download,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output dn_addr,
    output dn_data,
    output dn_wr,
    output dn_region
  );
endinterface

// File: rtl/scramble_dn_loader.sv
// ROM download loader: range-checks HPS bytes, forwards them to the core ROMs,
// and holds the core in reset until a fixed delay after the download ends.
module scramble_dn_loader #(
  parameter logic [15:0] ROM_SIZE  = 16'h6820,
  parameter logic [15:0] SND_BASE  = 16'h4000,
  parameter logic [15:0] GFX_BASE  = 16'h5800,
  parameter logic [15:0] PROM_BASE = 16'h6800,
  parameter int unsigned POST_RST  = 16
) (
  input  logic                     clk,
  input  logic                     RESET_n,
  scramble_dn_loader_if.slave      io,
  output logic                     core_reset,
  output logic                     dn_done,
  output logic                     err_ovf,
  output logic [15:0]              byte_count,
  output logic [7:0]               checksum
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(POST_RST - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic [1:0]  region_q, region_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  sum_q, sum_d;

  logic start;
  logic in_rng;
  logic wr_en;

  function automatic logic [1:0] region_of(input logic [15:0] a);
    if (a >= PROM_BASE)     return 2'd3;
    else if (a >= GFX_BASE) return 2'd2;
    else if (a >= SND_BASE) return 2'd1;
    else                    return 2'd0;
  endfunction

  // HOLD/RUN only see download high on a fresh download,
  // so any non-LOAD state with download high is a rising edge.
  assign start  = (state_q != LOAD) && io.ioctl_download;
  assign in_rng = (io.ioctl_addr[24:16] == 9'd0) &&
                  (io.ioctl_addr[15:0] < ROM_SIZE);
  assign wr_en  = io.ioctl_wr && ((state_q == LOAD) || start);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = 1'b0;
    region_d = region_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    sum_d    = sum_q;

    if (start) begin
      count_d = 16'd0;
      sum_d   = 8'd0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end

    if (wr_en && in_rng) begin
      wr_d     = 1'b1;
      addr_d   = io.ioctl_addr[15:0];
      data_d   = io.ioctl_dout;
      region_d = region_of(io.ioctl_addr[15:0]);
      if (count_d != 16'hFFFF) count_d = count_d + 16'd1;
      sum_d = sum_d + io.ioctl_dout;
    end else if (wr_en) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (io.ioctl_download) state_d = LOAD;
      end
      LOAD: begin
        if (!io.ioctl_download) begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      HOLD: begin
        if (io.ioctl_download) begin
          state_d = LOAD;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = RUN;
          done_d  = ~ovf_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RUN: begin
        if (io.ioctl_download) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 16'd0;
      data_q   <= 8'd0;
      wr_q     <= 1'b0;
      region_q <= 2'd0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= 16'd0;
      sum_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      region_q <= region_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
    end
  end

  assign io.dn_addr   = addr_q;
  assign io.dn_data   = data_q;
  assign io.dn_wr     = wr_q;
  assign io.dn_region = region_q;
  assign core_reset   = (state_q != RUN);
  assign dn_done      = done_q;
  assign err_ovf      = ovf_q;
  assign byte_count   = count_q;
  assign checksum     = sum_q;

endmodule

// File: tb/tb_scramble_dn_loader.sv
// Directed bench for scramble_dn_loader: reset, edge write, region decode,
// overflow, restart in HOLD, full ROM load and asynchronous reset.
module tb_scramble_dn_loader;

  logic        clk;
  logic        RESET_n;
  logic        core_reset;
  logic        dn_done;
  logic        err_ovf;
  logic [15:0] byte_count;
  logic [7:0]  checksum;

  int tests = 0;
  int fails = 0;

  scramble_dn_loader_if bus ();

  scramble_dn_loader dut (
    .clk        (clk),
    .RESET_n    (RESET_n),
    .io         (bus),
    .core_reset (core_reset),
    .dn_done    (dn_done),
    .err_ovf    (err_ovf),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  // Drops download and counts samples with core_reset still high.
  task automatic end_dl(output int n);
    n = 0;
    bus.ioctl_download = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (core_reset) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0]  msum;
    logic [15:0] raddr [6];
    logic [1:0]  rreg  [6];

    raddr = '{16'h3FFF, 16'h4000, 16'h57FF, 16'h5800, 16'h67FF, 16'h6800};
    rreg  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

    RESET_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    #12;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_dn_wr", 32'(bus.dn_wr), 32'd0);
    chk("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
    chk("rst_dn_data", 32'(bus.dn_data), 32'd0);
    chk("rst_region", 32'(bus.dn_region), 32'd0);
    chk("rst_done", 32'(dn_done), 32'd0);
    chk("rst_ovf", 32'(err_ovf), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_sum", 32'(checksum), 32'd0);
    RESET_n = 1'b1;
    tick();

    wr_byte(25'h5, 8'h12);
    chk("idle_wr_ign", 32'(bus.dn_wr), 32'd0);
    chk("idle_count", 32'(byte_count), 32'd0);
    chk("idle_core_reset", 32'(core_reset), 32'd1);

    bus.ioctl_download = 1'b1;
    wr_byte(25'h0, 8'hA5);
    chk("edge_dn_wr", 32'(bus.dn_wr), 32'd1);
    chk("edge_dn_addr", 32'(bus.dn_addr), 32'd0);
    chk("edge_dn_data", 32'(bus.dn_data), 32'hA5);
    chk("edge_count", 32'(byte_count), 32'd1);
    chk("edge_sum", 32'(checksum), 32'hA5);
    tick();
    chk("edge_wr_1cyc", 32'(bus.dn_wr), 32'd0);
    chk("edge_data_hold", 32'(bus.dn_data), 32'hA5);
    end_dl(n);
    chk("edge_hold_len", 32'(n), 32'd16);
    chk("edge_done", 32'(dn_done), 32'd1);
    chk("edge_run", 32'(core_reset), 32'd0);

    wr_byte(25'h10, 8'h33);
    chk("run_wr_ign", 32'(bus.dn_wr), 32'd0);
    chk("run_count", 32'(byte_count), 32'd1);

    bus.ioctl_download = 1'b1;
    tick();
    chk("reg_clr_count", 32'(byte_count), 32'd0);
    chk("reg_clr_done", 32'(dn_done), 32'd0);
    chk("reg_core_reset", 32'(core_reset), 32'd1);
    for (int i = 0; i < 6; i++) begin
      wr_byte({9'd0, raddr[i]}, 8'(8'h10 + i));
      chk("reg_dn_wr", 32'(bus.dn_wr), 32'd1);
      chk("reg_dn_addr", 32'(bus.dn_addr), 32'(raddr[i]));
      chk("reg_region", 32'(bus.dn_region), 32'(rreg[i]));
    end
    chk("reg_count", 32'(byte_count), 32'd6);
    chk("reg_sum", 32'(checksum), 32'h6F);
    end_dl(n);
    chk("reg_hold_len", 32'(n), 32'd16);
    chk("reg_done", 32'(dn_done), 32'd1);

    bus.ioctl_download = 1'b1;
    wr_byte(25'h0100, 8'h7E);
    chk("ovf_first", 32'(byte_count), 32'd1);
    wr_byte(25'h6820, 8'h11);
    chk("ovf_a_dn_wr", 32'(bus.dn_wr), 32'd0);
    chk("ovf_a_count", 32'(byte_count), 32'd1);
    chk("ovf_a_sum", 32'(checksum), 32'h7E);
    chk("ovf_a_flag", 32'(err_ovf), 32'd1);
    wr_byte(25'h1_0000, 8'h22);
    chk("ovf_b_dn_wr", 32'(bus.dn_wr), 32'd0);
    chk("ovf_b_addr", 32'(bus.dn_addr), 32'h0100);
    chk("ovf_b_count", 32'(byte_count), 32'd1);
    end_dl(n);
    chk("ovf_hold_len", 32'(n), 32'd16);
    chk("ovf_done", 32'(dn_done), 32'd0);
    chk("ovf_core_reset", 32'(core_reset), 32'd0);
    chk("ovf_sticky", 32'(err_ovf), 32'd1);

    bus.ioctl_download = 1'b1;
    wr_byte(25'h20, 8'h40);
    chk("rs_ovf_clr", 32'(err_ovf), 32'd0);
    wr_byte(25'h21, 8'h41);
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rs_hold_cr", 32'(core_reset), 32'd1);
    end
    bus.ioctl_download = 1'b1;
    tick();
    chk("rs_core_reset", 32'(core_reset), 32'd1);
    chk("rs_count_clr", 32'(byte_count), 32'd0);
    chk("rs_sum_clr", 32'(checksum), 32'd0);
    wr_byte(25'h30, 8'h05);
    end_dl(n);
    chk("rs_hold_len", 32'(n), 32'd16);
    chk("rs_done", 32'(dn_done), 32'd1);
    chk("rs_count", 32'(byte_count), 32'd1);
    chk("rs_sum", 32'(checksum), 32'h05);

    bad  = 0;
    msum = 8'd0;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 32'h6820; i++) begin
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i);
      bus.ioctl_wr   = 1'b1;
      msum = msum + 8'(i);
      tick();
      if (!(bus.dn_wr === 1'b1 && bus.dn_addr === 16'(i) &&
            bus.dn_data === 8'(i)))
        bad++;
    end
    bus.ioctl_wr = 1'b0;
    end_dl(n);
    chk("full_bad_pulses", 32'(bad), 32'd0);
    chk("full_dn_wr_off", 32'(bus.dn_wr), 32'd0);
    chk("full_count", 32'(byte_count), 32'h6820);
    chk("full_sum", 32'(checksum), 32'(msum));
    chk("full_hold_len", 32'(n), 32'd16);
    chk("full_done", 32'(dn_done), 32'd1);

    bus.ioctl_download = 1'b1;
    wr_byte(25'h1234, 8'h99);
    chk("ar_pre_addr", 32'(bus.dn_addr), 32'h1234);
    bus.ioctl_addr = 25'h55;
    bus.ioctl_wr   = 1'b1;
    #3;
    RESET_n = 1'b0;
    #1;
    chk("ar_core_reset", 32'(core_reset), 32'd1);
    chk("ar_dn_wr", 32'(bus.dn_wr), 32'd0);
    chk("ar_dn_addr", 32'(bus.dn_addr), 32'd0);
    chk("ar_dn_data", 32'(bus.dn_data), 32'd0);
    chk("ar_region", 32'(bus.dn_region), 32'd0);
    chk("ar_count", 32'(byte_count), 32'd0);
    chk("ar_sum", 32'(checksum), 32'd0);
    chk("ar_done", 32'(dn_done), 32'd0);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    #2;
    RESET_n = 1'b1;
    repeat (3) tick();
    chk("ar_idle_cr", 32'(core_reset), 32'd1);
    chk("ar_idle_done", 32'(dn_done), 32'd0);
    chk("ar_idle_count", 32'(byte_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
